// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over req/ack, and hands IR/op to the control unit.
// Define FETCH_PREFETCH_EN to add a one-entry prefetch buffer for 1 instruction/cycle throughput.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_INC   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         op,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_W-1:0]   r_redir_pc, w_redir_pc_next;
  logic [ADDR_W-1:0]   r_pc, w_pc_next;
  logic [INSTR_W-1:0]  r_ir, w_ir_next;
  logic                r_ir_valid, w_ir_valid_next;
  logic                r_drop, w_drop_next;
  logic                w_ack, w_consume, w_take, w_full_next;
`ifdef FETCH_PREFETCH_EN
  logic [INSTR_W-1:0]  r_buf_data, w_buf_data_next;
  logic [ADDR_W-1:0]   r_buf_pc, w_buf_pc_next;
  logic                r_buf_valid, w_buf_valid_next;
`endif

  assign w_ack     = (r_state == S_REQ) && imem_ack;
  assign w_consume = r_ir_valid && ir_ready;
  assign w_take    = w_ack && !r_drop && !redirect;

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_redir_pc_next = r_redir_pc;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_valid_next = r_ir_valid;
    w_drop_next     = r_drop;
`ifdef FETCH_PREFETCH_EN
    w_buf_data_next  = r_buf_data;
    w_buf_pc_next    = r_buf_pc;
    w_buf_valid_next = r_buf_valid;
`endif

    if (w_consume) begin
`ifdef FETCH_PREFETCH_EN
      w_ir_valid_next  = r_buf_valid;
      w_buf_valid_next = 1'b0;
      if (r_buf_valid) begin
        w_ir_next = r_buf_data;
        w_pc_next = r_buf_pc;
      end
`else
      w_ir_valid_next = 1'b0;
`endif
    end

    if (w_take) begin
      w_fetch_pc_next = r_fetch_pc + INC;
`ifdef FETCH_PREFETCH_EN
      // IR still occupied after this edge: park the word in the buffer
      if (w_ir_valid_next) begin
        w_buf_data_next  = imem_rdata;
        w_buf_pc_next    = r_fetch_pc;
        w_buf_valid_next = 1'b1;
      end else
`endif
      begin
        w_ir_next       = imem_rdata;
        w_pc_next       = r_fetch_pc;
        w_ir_valid_next = 1'b1;
      end
    end else if (w_ack && r_drop && !redirect) begin
      w_fetch_pc_next = r_redir_pc;
      w_drop_next     = 1'b0;
    end

`ifdef FETCH_PREFETCH_EN
    w_full_next = w_buf_valid_next;
`else
    w_full_next = w_ir_valid_next;
`endif

    case (r_state)
      S_IDLE:  w_state_next = S_REQ;
      S_REQ:   if (w_ack) w_state_next = w_full_next ? S_HOLD : S_REQ;
      S_HOLD:  if (!w_full_next) w_state_next = S_REQ;
      default: w_state_next = S_IDLE;
    endcase

    // The outstanding address stays on the bus; the target is applied once its ack arrives
    if (redirect) begin
      w_ir_valid_next = 1'b0;
`ifdef FETCH_PREFETCH_EN
      w_buf_valid_next = 1'b0;
`endif
      w_state_next = S_REQ;
      if ((r_state == S_REQ) && !imem_ack) begin
        w_drop_next     = 1'b1;
        w_redir_pc_next = redirect_pc;
      end else begin
        w_fetch_pc_next = redirect_pc;
        w_drop_next     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_redir_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_drop     <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      r_buf_data  <= '0;
      r_buf_pc    <= RESET_PC;
      r_buf_valid <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_redir_pc <= w_redir_pc_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_valid <= w_ir_valid_next;
      r_drop     <= w_drop_next;
`ifdef FETCH_PREFETCH_EN
      r_buf_data  <= w_buf_data_next;
      r_buf_pc    <= w_buf_pc_next;
      r_buf_valid <= w_buf_valid_next;
`endif
    end
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_fetch_pc;
  assign ir        = r_ir;
  assign op        = r_ir[INSTR_W-1 -: 4];
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign pc_plus   = r_pc + INC;

endmodule
